// File: rtl/feistel_pkg.sv
// Shared constants, FSM state type and round-count clamp for the iterative Feistel core.
package feistel_pkg;

    localparam int MAX_ROUND  = 8;
    localparam int SBOX_WIDTH = 8;
    localparam int KEY_SIZE   = 128;
    localparam int DATA_WIDTH = 256;
    localparam int ROT        = 8;

    localparam int HALF       = DATA_WIDTH / 2;
    localparam int LANES      = HALF / SBOX_WIDTH;
    localparam int SBOX_DEPTH = 2 ** SBOX_WIDTH;
    localparam int KEY_AW     = $clog2(MAX_ROUND);
    localparam int CFG_W      = KEY_AW + 1;

    typedef enum logic [1:0] {
        LOAD,
        IDLE,
        ROUND,
        OUT
    } state_e;

    // Zero rounds would never produce a block, so it is promoted to one.
    function automatic int clamp_rounds(input int cfg);
        if (cfg < 1) return 1;
        if (cfg > MAX_ROUND) return MAX_ROUND;
        return cfg;
    endfunction

endpackage

// File: rtl/feistel_cipher_iter_if.sv
// Block input/output handshake bundle between the pixel packer, the cipher and the serializer.
interface feistel_cipher_iter_if;
    import feistel_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic                  s_mode;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output s_valid, s_mode, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_mode, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

endinterface

// File: rtl/feistel_round_f.sv
// Round function F(R,k) = rotl(S(R ^ k), ROT) with a per-lane lookup into the flattened S-box.
module feistel_round_f
    import feistel_pkg::*;
(
    input  logic [HALF-1:0]                  r,
    input  logic [HALF-1:0]                  k,
    input  logic [SBOX_DEPTH*SBOX_WIDTH-1:0] sbox_flat,
    output logic [HALF-1:0]                  f
);

    localparam int FLAT_AW = $clog2(SBOX_DEPTH * SBOX_WIDTH);

    logic [HALF-1:0]    mixed;
    logic [HALF-1:0]    subst;
    logic [FLAT_AW-1:0] base;

    always_comb begin
        mixed = r ^ k;
        subst = '0;
        base  = '0;
        for (int j = 0; j < LANES; j++) begin
            base = FLAT_AW'(mixed[j*SBOX_WIDTH +: SBOX_WIDTH]) * FLAT_AW'(SBOX_WIDTH);
            subst[j*SBOX_WIDTH +: SBOX_WIDTH] = sbox_flat[base +: SBOX_WIDTH];
        end
    end

    assign f = {subst[HALF-ROT-1:0], subst[HALF-1:HALF-ROT]};

endmodule

// File: rtl/feistel_cipher_iter.sv
// Iterative Feistel cipher: one round per clock over a shared datapath, loadable S-box and key file.
module feistel_cipher_iter
    import feistel_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    input  logic                  sbox_valid,
    input  logic                  sbox_reload,
    output logic                  sbox_ready,
    input  logic                  key_we,
    input  logic [KEY_AW-1:0]     key_addr,
    input  logic [KEY_SIZE-1:0]   key_data,
    input  logic [CFG_W-1:0]      cfg_rounds,
    output logic                  busy,
    feistel_cipher_iter_if.slave  bus
);

    state_e                state_q, state_d;
    logic [SBOX_WIDTH-1:0] idx_q, idx_d;
    logic [HALF-1:0]       l_q, l_d;
    logic [HALF-1:0]       r_q, r_d;
    logic                  mode_q, mode_d;
    logic [CFG_W-1:0]      n_q, n_d;
    logic [KEY_AW-1:0]     i_q, i_d;

    logic [SBOX_WIDTH-1:0]           sbox_mem [SBOX_DEPTH];
    logic [KEY_SIZE-1:0]             key_mem  [MAX_ROUND];
    logic [SBOX_DEPTH*SBOX_WIDTH-1:0] sbox_flat;

    logic                  sbox_we;
    logic                  key_wr;
    logic [KEY_AW-1:0]     key_idx;
    logic [KEY_SIZE-1:0]   round_key;
    logic [HALF-1:0]       f_out;
    logic                  last_round;

    for (genvar e = 0; e < SBOX_DEPTH; e++) begin : g_flat
        assign sbox_flat[e*SBOX_WIDTH +: SBOX_WIDTH] = sbox_mem[e];
    end

    // Decryption walks the key file backwards from the last round actually used.
    assign key_idx    = mode_q ? KEY_AW'(n_q - CFG_W'(1) - CFG_W'(i_q)) : i_q;
    assign round_key  = key_mem[key_idx];
    assign last_round = (CFG_W'(i_q) == n_q - CFG_W'(1));

    feistel_round_f u_round_f (
        .r         (r_q),
        .k         (round_key),
        .sbox_flat (sbox_flat),
        .f         (f_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        l_d     = l_q;
        r_d     = r_q;
        mode_d  = mode_q;
        n_d     = n_q;
        i_d     = i_q;
        sbox_we = 1'b0;
        key_wr  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (sbox_valid) begin
                    sbox_we = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == '1) state_d = IDLE;
                end
            end
            IDLE: begin
                key_wr = key_we && (int'(key_addr) < MAX_ROUND);
                if (sbox_reload) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end else if (bus.s_valid) begin
                    l_d     = bus.s_data[DATA_WIDTH-1:HALF];
                    r_d     = bus.s_data[HALF-1:0];
                    mode_d  = bus.s_mode;
                    n_d     = CFG_W'(clamp_rounds(int'(cfg_rounds)));
                    i_d     = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                l_d = r_q;
                r_d = l_q ^ f_out;
                i_d = i_q + 1'b1;
                if (last_round) state_d = OUT;
            end
            OUT: begin
                if (bus.m_ready) state_d = IDLE;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            mode_q  <= 1'b0;
            n_q     <= CFG_W'(1);
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            l_q     <= l_d;
            r_q     <= r_d;
            mode_q  <= mode_d;
            n_q     <= n_d;
            i_q     <= i_d;
        end
    end

    // Table and key storage are deliberately unreset so the key file survives a reset.
    always_ff @(posedge clk) begin
        if (sbox_we) sbox_mem[idx_q]   <= sbox_out;
        if (key_wr)  key_mem[key_addr] <= key_data;
    end

    assign sbox_ready  = (state_q != LOAD);
    assign busy        = (state_q == ROUND) || (state_q == OUT);
    assign bus.s_ready = (state_q == IDLE);
    assign bus.m_valid = (state_q == OUT);
    assign bus.m_data  = (state_q == OUT) ? {r_q, l_q} : '0;

endmodule

// File: tb/tb_feistel_cipher_iter.sv
// Self-checking bench: table-driven vectors against a Feistel model, scoreboarded outputs, corner sequences.
module tb_feistel_cipher_iter;
    import feistel_pkg::*;

    typedef struct {
        logic                  mode;
        int                    rounds;
        logic [DATA_WIDTH-1:0] din;
        logic [DATA_WIDTH-1:0] dout;
    } vec_t;

    logic                  clk;
    logic                  reset_n;
    logic [SBOX_WIDTH-1:0] sbox_out;
    logic                  sbox_valid;
    logic                  sbox_reload;
    logic                  sbox_ready;
    logic                  key_we;
    logic [KEY_AW-1:0]     key_addr;
    logic [KEY_SIZE-1:0]   key_data;
    logic [CFG_W-1:0]      cfg_rounds;
    logic                  busy;

    feistel_cipher_iter_if bus_if ();

    feistel_cipher_iter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sbox_out    (sbox_out),
        .sbox_valid  (sbox_valid),
        .sbox_reload (sbox_reload),
        .sbox_ready  (sbox_ready),
        .key_we      (key_we),
        .key_addr    (key_addr),
        .key_data    (key_data),
        .cfg_rounds  (cfg_rounds),
        .busy        (busy),
        .bus         (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int out_seen = 0;

    logic [SBOX_WIDTH-1:0] sbox_m [SBOX_DEPTH];
    logic [KEY_SIZE-1:0]   key_m  [MAX_ROUND];
    logic [DATA_WIDTH-1:0] sb_q[$];
    logic [DATA_WIDTH-1:0] mon_want;
    vec_t                  vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [DATA_WIDTH-1:0] act,
                                input logic [DATA_WIDTH-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, want);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic int tb_clamp(input int r);
        return (r == 0) ? 1 : ((r > MAX_ROUND) ? MAX_ROUND : r);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rand256();
        logic [DATA_WIDTH-1:0] v;
        for (int w = 0; w < DATA_WIDTH / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference Feistel network built from the bench's own copies of the table and keys.
    function automatic logic [DATA_WIDTH-1:0] model(input logic mode, input int rounds,
                                                    input logic [DATA_WIDTH-1:0] din);
        int n;
        logic [HALF-1:0] l, r, k, x, s, f, t;
        n = tb_clamp(rounds);
        l = din[DATA_WIDTH-1:HALF];
        r = din[HALF-1:0];
        for (int i = 0; i < n; i++) begin
            k = mode ? key_m[n-1-i] : key_m[i];
            x = r ^ k;
            for (int j = 0; j < LANES; j++) s[j*8 +: 8] = sbox_m[x[j*8 +: 8]];
            f = (s << ROT) | (s >> (HALF - ROT));
            t = l ^ f;
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    // An output handshake completes on the next rising edge; compare it against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && bus_if.m_valid && bus_if.m_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL unexpected_output: got %h, expected no block", bus_if.m_data);
            end else begin
                mon_want = sb_q.pop_front();
                check_output($sformatf("out_data_%0d", out_seen), bus_if.m_data, mon_want);
            end
            out_seen++;
        end
    end

    task automatic load_sbox(input int kind);
        logic [SBOX_WIDTH-1:0] v;
        for (int e = 0; e < SBOX_DEPTH; e++) begin
            case (kind)
                0:       v = '0;
                1:       v = SBOX_WIDTH'(e);
                default: v = SBOX_WIDTH'($urandom_range(0, 255));
            endcase
            sbox_m[e]  = v;
            sbox_out   = v;
            sbox_valid = 1'b1;
            if (e == SBOX_DEPTH - 1) check_bit("sbox_ready_before_last", sbox_ready, 1'b0);
            @(posedge clk); #1;
            if (e % 61 == 7) begin
                sbox_valid = 1'b0;
                sbox_out   = ~v;
                @(posedge clk); #1;
            end
        end
        sbox_valid = 1'b0;
        check_bit("sbox_ready_loaded", sbox_ready, 1'b1);
        check_bit("s_ready_loaded", bus_if.s_ready, 1'b1);
    endtask

    task automatic reload_sbox(input int kind);
        sbox_reload = 1'b1;
        @(posedge clk); #1;
        sbox_reload = 1'b0;
        check_bit("reload_sbox_ready", sbox_ready, 1'b0);
        check_bit("reload_s_ready", bus_if.s_ready, 1'b0);
        load_sbox(kind);
    endtask

    task automatic write_key(input int a, input logic [KEY_SIZE-1:0] v);
        key_we   = 1'b1;
        key_addr = KEY_AW'(a);
        key_data = v;
        @(posedge clk); #1;
        key_we   = 1'b0;
        key_m[a] = v;
    endtask

    task automatic apply_stimulus(input logic mode, input int rounds,
                                  input logic [DATA_WIDTH-1:0] data,
                                  input logic [DATA_WIDTH-1:0] want);
        int t;
        bus_if.s_mode  = mode;
        bus_if.s_data  = data;
        cfg_rounds     = CFG_W'(rounds);
        bus_if.s_valid = 1'b1;
        t = 0;
        while (!bus_if.s_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus_if.s_ready) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL accept_timeout: got s_ready=0, expected 1 within 50 cycles");
            bus_if.s_valid = 1'b0;
            return;
        end
        sb_q.push_back(want);
        @(posedge clk); #1;
        bus_if.s_valid = 1'b0;
    endtask

    task automatic measure_latency(output int lat);
        lat = 0;
        while (!bus_if.m_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_int({name, "_drained"}, sb_q.size(), 0);
    endtask

    task automatic check_output_block(input string name, input logic mode, input int rounds,
                                      input logic [DATA_WIDTH-1:0] data,
                                      input logic [DATA_WIDTH-1:0] want);
        int lat;
        apply_stimulus(mode, rounds, data, want);
        measure_latency(lat);
        check_int({name, "_latency"}, lat, tb_clamp(rounds));
        wait_drain(name);
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] d, e, pt, ct;
        logic [KEY_SIZE-1:0]   k;
        int                    lat;

        reset_n        = 1'b0;
        sbox_out       = '0;
        sbox_valid     = 1'b0;
        sbox_reload    = 1'b0;
        key_we         = 1'b0;
        key_addr       = '0;
        key_data       = '0;
        cfg_rounds     = '0;
        bus_if.s_valid = 1'b0;
        bus_if.s_mode  = 1'b0;
        bus_if.s_data  = '0;
        bus_if.m_ready = 1'b1;
        #12;
        check_bit("rst_sbox_ready", sbox_ready, 1'b0);
        check_bit("rst_s_ready", bus_if.s_ready, 1'b0);
        check_bit("rst_m_valid", bus_if.m_valid, 1'b0);
        check_output("rst_m_data", bus_if.m_data, '0);
        check_bit("rst_busy", busy, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] zero S-box: single round passes the block through");
        load_sbox(0);
        for (int a = 0; a < MAX_ROUND; a++) begin
            d = rand256();
            write_key(a, d[KEY_SIZE-1:0]);
        end
        d = rand256();
        check_output_block("zero_sbox", 1'b0, 1, d, d);

        $display("[TB] identity S-box known answer");
        reload_sbox(1);
        write_key(0, '0);
        check_output_block("identity", 1'b0, 1, {128'h0, 128'h1}, {128'h100, 128'h1});

        $display("[TB] round trip with five sequential keys");
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 16; b++) k[127-8*b -: 8] = 8'(16 * i + b);
            write_key(i, k);
        end
        pt = 256'h11223344_55667788_99AABBCC_DDEEFF00_00112233_44556677_8899AABB_CCDDEEFF;
        ct = model(1'b0, 5, pt);
        check_output_block("rt_enc", 1'b0, 5, pt, ct);
        check_output_block("rt_dec", 1'b1, 5, ct, pt);

        $display("[TB] random S-box and keys, vector table");
        reload_sbox(2);
        for (int a = 0; a < MAX_ROUND; a++) begin
            d = rand256();
            write_key(a, d[KEY_SIZE-1:0]);
        end
        vecs[0] = '{1'b0, 0,  rand256(), '0};
        vecs[1] = '{1'b0, 15, rand256(), '0};
        vecs[2] = '{1'b1, 8,  rand256(), '0};
        vecs[3] = '{1'b0, 3,  rand256(), '0};
        vecs[4] = '{1'b1, 2,  rand256(), '0};
        vecs[5] = '{1'b0, 8,  rand256(), '0};
        vecs[6] = '{1'b1, 0,  rand256(), '0};
        for (int i = 0; i < 7; i++) vecs[i].dout = model(vecs[i].mode, vecs[i].rounds, vecs[i].din);
        pt = rand256();
        vecs[7] = '{1'b1, 15, model(1'b0, 15, pt), pt};
        for (int i = 0; i < 8; i++)
            check_output_block($sformatf("vec%0d", i), vecs[i].mode, vecs[i].rounds,
                               vecs[i].din, vecs[i].dout);

        $display("[TB] backpressure with ignored key write and reload while busy");
        bus_if.m_ready = 1'b0;
        d = rand256();
        e = model(1'b0, 2, d);
        apply_stimulus(1'b0, 2, d, e);
        measure_latency(lat);
        check_int("bp_latency", lat, 2);
        for (int c = 0; c < 10; c++) begin
            check_bit($sformatf("bp_m_valid_%0d", c), bus_if.m_valid, 1'b1);
            check_output($sformatf("bp_m_data_%0d", c), bus_if.m_data, e);
            check_bit($sformatf("bp_s_ready_%0d", c), bus_if.s_ready, 1'b0);
            key_we      = (c == 3);
            key_addr    = '0;
            key_data    = ~key_m[0];
            sbox_reload = (c == 5);
            @(posedge clk); #1;
        end
        key_we      = 1'b0;
        sbox_reload = 1'b0;
        check_bit("bp_reload_ignored", sbox_ready, 1'b1);
        bus_if.m_ready = 1'b1;
        @(posedge clk); #1;
        check_bit("bp_release_m_valid", bus_if.m_valid, 1'b0);
        check_bit("bp_release_s_ready", bus_if.s_ready, 1'b1);
        check_int("bp_popped", sb_q.size(), 0);
        d = rand256();
        check_output_block("key0_kept", 1'b0, 1, d, model(1'b0, 1, d));

        $display("[TB] reload takes priority over a simultaneous block");
        bus_if.s_data  = rand256();
        cfg_rounds     = CFG_W'(1);
        bus_if.s_valid = 1'b1;
        sbox_reload    = 1'b1;
        @(posedge clk); #1;
        bus_if.s_valid = 1'b0;
        sbox_reload    = 1'b0;
        check_bit("prio_busy", busy, 1'b0);
        check_bit("prio_sbox_ready", sbox_ready, 1'b0);
        check_bit("prio_s_ready", bus_if.s_ready, 1'b0);
        load_sbox(2);
        d = rand256();
        check_output_block("after_reload", 1'b1, 4, d, model(1'b1, 4, d));

        $display("[TB] reset in the middle of a block");
        d = rand256();
        apply_stimulus(1'b0, 8, d, model(1'b0, 8, d));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_bit("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        check_bit("mid_rst_m_valid", bus_if.m_valid, 1'b0);
        check_bit("mid_rst_sbox_ready", sbox_ready, 1'b0);
        check_bit("mid_rst_s_ready", bus_if.s_ready, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_bit("post_rst_sbox_ready", sbox_ready, 1'b0);
        check_bit("post_rst_s_ready", bus_if.s_ready, 1'b0);
        check_bit("post_rst_m_valid", bus_if.m_valid, 1'b0);
        load_sbox(1);
        d = rand256();
        check_output_block("keys_after_reset", 1'b0, 4, d, model(1'b0, 4, d));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/feistel_cipher_iter.md
# feistel_cipher_iter

Iterative, parametrised Feistel cipher core with run-time encrypt/decrypt mode, programmable round count, a writable round-key file and valid/ready handshakes on both data sides. It is the next generation of the fixed-round `feistel_encrypt`. The S-box is loaded once from the chaotic S-box generator stream; data blocks then stream from the image pixel packer and return to the output serializer. One Feistel round executes per clock over a single shared round datapath.

## Interface
- MAX_ROUND, 8: key-file depth and maximum rounds per block.
- SBOX_WIDTH, 8: S-box input/output width; table holds 2^SBOX_WIDTH entries.
- KEY_SIZE, 128: round-key width; must equal DATA_WIDTH/2.
- DATA_WIDTH, 256: block width; multiple of 2*SBOX_WIDTH.
- ROT, 8: left-rotate amount applied inside F.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sbox_out  in  SBOX_WIDTH  S-box entry stream; entry index auto-increments from 0.
- sbox_valid  in  1  qualifies sbox_out; ignored outside LOAD.
- sbox_reload  in  1  pulse in IDLE: restart S-box load.
- sbox_ready  out  1  high when the full table is loaded.
- key_we  in  1  round-key write strobe; ignored unless in IDLE.
- key_addr  in  $clog2(MAX_ROUND)  round-key index.
- key_data  in  KEY_SIZE  round-key value.
- cfg_rounds  in  $clog2(MAX_ROUND)+1  rounds for the next block; sampled at accept.
- s_valid / s_ready  in / out  1  input handshake.
- s_mode  in  1  0 = encrypt, 1 = decrypt.
- s_data  in  DATA_WIDTH  input block {L,R}; L = upper half.
- m_valid / m_ready  out / in  1  output handshake.
- m_data  out  DATA_WIDTH  result block.
- busy  out  1  high in ROUND or OUT.

## Operation
- **FSM states:** LOAD, IDLE, ROUND, OUT.
- **Reset:** state LOAD. Outputs sbox_ready=0, s_ready=0, m_valid=0, m_data=0, busy=0.
  - The S-box table and key file have no reset; their contents are undefined until written.
- **LOAD**
  - Each sbox_valid cycle writes sbox_out to table[idx], then idx++.
  - After entry 2^SBOX_WIDTH-1 is written: idx wraps to 0, sbox_ready=1, next state IDLE.
- **IDLE**
  - s_ready=1.
  - sbox_reload → LOAD, with sbox_ready=0 and idx=0. sbox_reload takes priority over s_valid in the same cycle.
  - key_we writes key[key_addr]. An address ≥ MAX_ROUND is ignored.
  - On s_valid&&s_ready:
    - latch s_data into L,R and latch s_mode.
    - latch n = clamp(cfg_rounds): 0→1, >MAX_ROUND→MAX_ROUND.
    - set i=0, next state ROUND.
- **ROUND**, one round per cycle:
  - k = key[i] if encrypt, key[n-1-i] if decrypt.
  - F(R,k) = rotl(S(R^k), ROT), where S substitutes each SBOX_WIDTH-bit lane via the table.
  - L ← R; R ← L^F(R,k); i++.
  - After round n-1: next state OUT.
- **OUT**
  - m_data = {R,L} (final swap); m_valid=1.
  - Hold m_data and m_valid stable until m_ready; then m_valid=0 and next state IDLE.
- **Inverse property:** decrypt with the same keys and n inverts encrypt.

## Timing
- Accept at edge T; rounds run at edges T+1..T+n; m_valid is high from T+n onward.
- With m_ready=1, the next s_ready comes one cycle after the output handshake.
- Peak throughput is one block per n+2 cycles.
- s_ready=0 in LOAD, ROUND and OUT; no overlap between blocks.
- sbox_valid outside LOAD is ignored.
- Key writes and sbox_reload are ignored while busy.
- reset_n asserted mid-block: the block is dropped and the FSM returns to LOAD. After reset the S-box must be reloaded, but the key file persists.

## Structure
- **Package feistel_pkg:** state enum (LOAD, IDLE, ROUND, OUT), HALF=DATA_WIDTH/2 and LANES=HALF/SBOX_WIDTH constants, and a clamp_rounds function.
- **Sub-module feistel_round_f:** combinational XOR, per-lane S-box lookup and rotate.
  - Takes R, k and the flattened table as inputs.
  - Instantiated once in feistel_cipher_iter.
- **Top level:** FSM, round counter, table and key-file storage.

## Test plan
- **Zero S-box:** load all entries 0, cfg_rounds=1, encrypt s_data=X → m_data=X. Check m_valid rises 1 cycle after accept.
- **Identity S-box:** table[i]=i, key[0]=0, cfg_rounds=1, s_data={128'h0,128'h1} → m_data={128'h100,128'h1}.
- **Round trip:** identity S-box, keys K0..K4=0x0001..0F, 0x1011..1F, …, 0x4041..4F, cfg_rounds=5. Encrypt 256'h1122…EEFF_0011…EEFF, then decrypt the result → original block returned.
- **Backpressure:** hold m_ready=0 for 10 cycles → m_valid and m_data stable, s_ready=0. Release → handshake completes, then s_ready=1 the next cycle.
- **Clamping:** cfg_rounds=0 → latency 1 round; cfg_rounds=15 → latency MAX_ROUND rounds.
- **Reset mid-block:** assert reset_n low during ROUND → m_valid=0, sbox_ready=0, s_ready=0 until the table is reloaded.
